// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions: ExcCode values, controller state encoding and the
// default exception handler vector.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_VECTOR = 2'd2,
        ST_ERET   = 2'd3
    } state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle between the pipeline/CP0 side and the exception controller.
//   master : pipeline + CP0 register side (drives stage info, flags, EPC data)
//   slave  : exc_ctrl (drives EPC strobes, Cause/Status fields, flush/redirect)
interface exc_ctrl_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  m_valid;
    logic [31:0]           m_pc;
    logic                  m_bd;
    logic                  m_eret;
    logic                  exc_adel_if;
    logic                  exc_ri;
    logic                  exc_ov;
    logic                  exc_sys;
    logic                  exc_bp;
    logic                  exc_adel_d;
    logic                  exc_ades_d;
    logic [NUM_HW_INT-1:0] hw_int;
    logic [1:0]            sw_ip;
    logic                  status_ie;
    logic [7:0]            status_im;
    logic [31:0]           epc_rd;
    logic                  epc_we_h;
    logic                  epc_bd;
    logic [31:0]           epc_pc;
    logic                  epc_r_h;
    logic                  exl;
    logic [4:0]            exc_code;
    logic                  cause_bd;
    logic [NUM_HW_INT-1:0] ip_hw;
    logic                  flush;
    logic                  redirect;
    logic [31:0]           redirect_pc;

    modport master (
        output m_valid, m_pc, m_bd, m_eret,
        output exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades_d,
        output hw_int, sw_ip, status_ie, status_im, epc_rd,
        input  epc_we_h, epc_bd, epc_pc, epc_r_h, exl, exc_code, cause_bd, ip_hw,
        input  flush, redirect, redirect_pc
    );

    modport slave (
        input  m_valid, m_pc, m_bd, m_eret,
        input  exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades_d,
        input  hw_int, sw_ip, status_ie, status_im, epc_rd,
        output epc_we_h, epc_bd, epc_pc, epc_r_h, exl, exc_code, cause_bd, ip_hw,
        output flush, redirect, redirect_pc
    );

endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous inputs
//   q          : synchronised outputs, two clocks behind d
module exc_ctrl_int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller feeding the EPC unit.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : exc_ctrl_if.slave - memory-stage info, exception flags, interrupt
//         lines, Status/Cause inputs, EPC read data; EPC write/read strobes,
//         EXL, ExcCode, BD, synchronised IP, flush and fetch redirect.
//
// state  | meaning
// IDLE   | watch the M-stage instruction for exceptions / ERET
// FLUSH  | kill pipeline, write EPC (unless already at EXL)
// VECTOR | redirect fetch to the handler vector
// ERET   | read EPC, redirect fetch there, clear EXL
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          NUM_HW_INT = 6
) (
    input  logic         clk,
    input  logic         rst,
    exc_ctrl_if.slave    bus
);

    localparam int IPW = NUM_HW_INT + 2;

    state_t                state;
    logic                  exl_q;
    logic [4:0]            code_q;
    logic                  cause_bd_q;
    logic [31:0]           epc_pc_q;
    logic                  epc_bd_q;
    logic                  epc_we_q;
    logic                  epc_r_q;
    logic                  flush_q;
    logic                  redirect_q;
    logic [NUM_HW_INT-1:0] ip_hw_s;
    logic [IPW-1:0]        pend;
    logic                  int_req;
    logic                  take;
    logic [4:0]            code_sel;

    exc_ctrl_int_sync #(.WIDTH(NUM_HW_INT)) u_int_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (bus.hw_int),
        .q     (ip_hw_s)
    );

    assign pend    = {ip_hw_s, bus.sw_ip} & bus.status_im[IPW-1:0];
    assign int_req = bus.status_ie & ~exl_q & (|pend);

    always_comb begin
        take     = bus.m_valid;
        code_sel = EXC_INT;
        if (int_req)              code_sel = EXC_INT;
        else if (bus.exc_adel_if) code_sel = EXC_ADEL;
        else if (bus.exc_ri)      code_sel = EXC_RI;
        else if (bus.exc_ov)      code_sel = EXC_OV;
        else if (bus.exc_sys)     code_sel = EXC_SYS;
        else if (bus.exc_bp)      code_sel = EXC_BP;
        else if (bus.exc_adel_d)  code_sel = EXC_ADEL;
        else if (bus.exc_ades_d)  code_sel = EXC_ADES;
        else                      take     = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            exl_q      <= 1'b1;
            code_q     <= '0;
            cause_bd_q <= 1'b0;
            epc_pc_q   <= '0;
            epc_bd_q   <= 1'b0;
            epc_we_q   <= 1'b0;
            epc_r_q    <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            epc_we_q   <= 1'b0;
            epc_r_q    <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        code_q     <= code_sel;
                        cause_bd_q <= bus.m_bd;
                        epc_pc_q   <= bus.m_pc;
                        epc_bd_q   <= bus.m_bd;
                        // Nested exceptions keep the original return address.
                        epc_we_q   <= ~exl_q;
                        flush_q    <= 1'b1;
                        state      <= ST_FLUSH;
                    end else if (bus.m_valid && bus.m_eret) begin
                        epc_r_q    <= 1'b1;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                        state      <= ST_ERET;
                    end
                end
                ST_FLUSH: begin
                    exl_q      <= 1'b1;
                    flush_q    <= 1'b1;
                    redirect_q <= 1'b1;
                    state      <= ST_VECTOR;
                end
                ST_VECTOR: state <= ST_IDLE;
                ST_ERET: begin
                    exl_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // EPC data is only valid while the read strobe is up, so it is forwarded
    // straight through during ERET rather than registered.
    assign bus.redirect_pc = (state == ST_ERET) ? bus.epc_rd : EXC_VECTOR;
    assign bus.epc_we_h    = epc_we_q;
    assign bus.epc_bd      = epc_bd_q;
    assign bus.epc_pc      = epc_pc_q;
    assign bus.epc_r_h     = epc_r_q;
    assign bus.exl         = exl_q;
    assign bus.exc_code    = code_q;
    assign bus.cause_bd    = cause_bd_q;
    assign bus.ip_hw       = ip_hw_s;
    assign bus.flush       = flush_q;
    assign bus.redirect    = redirect_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [31:0] epc_model = '0;

    exc_ctrl_if #(.NUM_HW_INT(6)) bus ();

    exc_ctrl #(.EXC_VECTOR(VEC), .NUM_HW_INT(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the EPC register: captures epc_pc on the hardware strobe.
    always @(posedge clk) if (bus.epc_we_h) epc_model <= bus.epc_pc;

    typedef struct {
        logic        clr_exl;
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic        eret;
        logic [6:0]  exc;   // {adel_if, ri, ov, sys, bp, adel_d, ades_d}
        logic [1:0]  sw;
        logic        ie;
        logic [7:0]  im;
        logic        take;
        logic [4:0]  code;
        logic        we;
        logic        is_eret;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_valid     = 1'b0;
        bus.m_pc        = '0;
        bus.m_bd        = 1'b0;
        bus.m_eret      = 1'b0;
        bus.exc_adel_if = 1'b0;
        bus.exc_ri      = 1'b0;
        bus.exc_ov      = 1'b0;
        bus.exc_sys     = 1'b0;
        bus.exc_bp      = 1'b0;
        bus.exc_adel_d  = 1'b0;
        bus.exc_ades_d  = 1'b0;
        bus.hw_int      = '0;
        bus.sw_ip       = '0;
        bus.status_ie   = 1'b0;
        bus.status_im   = '0;
    endtask

    task automatic set_exc(input logic [6:0] e);
        {bus.exc_adel_if, bus.exc_ri, bus.exc_ov, bus.exc_sys,
         bus.exc_bp, bus.exc_adel_d, bus.exc_ades_d} = e;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        rst = 1'b1;
    endtask

    task automatic do_eret(input logic [31:0] addr);
        bus.epc_rd  = addr;
        bus.m_valid = 1'b1;
        bus.m_eret  = 1'b1;
        step();
        chk("eret_r_h", 32'(bus.epc_r_h), 32'd1);
        chk("eret_redirect", 32'(bus.redirect), 32'd1);
        chk("eret_redirect_pc", bus.redirect_pc, addr);
        chk("eret_flush", 32'(bus.flush), 32'd1);
        bus.m_valid = 1'b0;
        bus.m_eret  = 1'b0;
        step();
        chk("eret_exl", 32'(bus.exl), 32'd0);
        chk("eret_idle_redirect", 32'(bus.redirect), 32'd0);
    endtask

    initial begin
        clear_inputs();
        bus.epc_rd = '0;

        vecs[0]  = '{1'b1, 1'b1, 32'h0040_0010, 1'b0, 1'b0, 7'b0010000, 2'b00, 1'b0, 8'h00, 1'b1, 5'd12, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0040_0024, 1'b1, 1'b0, 7'b0001000, 2'b00, 1'b0, 8'h00, 1'b1, 5'd8,  1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h0040_0030, 1'b0, 1'b0, 7'b0110100, 2'b00, 1'b0, 8'h00, 1'b1, 5'd10, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0040_0034, 1'b0, 1'b1, 7'b0110100, 2'b00, 1'b0, 8'h00, 1'b1, 5'd10, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b0, 7'b1100000, 2'b00, 1'b0, 8'h00, 1'b1, 5'd4,  1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0040_0044, 1'b1, 1'b0, 7'b0000110, 2'b00, 1'b0, 8'h00, 1'b1, 5'd9,  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0040_0048, 1'b0, 1'b0, 7'b0000011, 2'b00, 1'b0, 8'h00, 1'b1, 5'd4,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0040_004C, 1'b0, 1'b0, 7'b0000001, 2'b00, 1'b0, 8'h00, 1'b1, 5'd5,  1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0040_0050, 1'b0, 1'b0, 7'b0010000, 2'b00, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0040_0054, 1'b0, 1'b0, 7'b0010000, 2'b01, 1'b1, 8'h01, 1'b1, 5'd0,  1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0040_0058, 1'b0, 1'b0, 7'b0010000, 2'b01, 1'b0, 8'h01, 1'b1, 5'd12, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h0040_005C, 1'b0, 1'b0, 7'b0000000, 2'b10, 1'b1, 8'h01, 1'b0, 5'd0,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h0040_0060, 1'b0, 1'b0, 7'b0000000, 2'b01, 1'b1, 8'hFF, 1'b0, 5'd0,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0040_0064, 1'b1, 1'b0, 7'b0010000, 2'b00, 1'b0, 8'h00, 1'b1, 5'd12, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h0040_0068, 1'b0, 1'b1, 7'b0000000, 2'b00, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h0040_006C, 1'b0, 1'b1, 7'b0000000, 2'b00, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b0};

        // Reset values
        step();
        chk("rst_exl", 32'(bus.exl), 32'd1);
        chk("rst_exc_code", 32'(bus.exc_code), 32'd0);
        chk("rst_cause_bd", 32'(bus.cause_bd), 32'd0);
        chk("rst_epc_pc", bus.epc_pc, 32'd0);
        chk("rst_epc_bd", 32'(bus.epc_bd), 32'd0);
        chk("rst_ip_hw", 32'(bus.ip_hw), 32'd0);
        chk("rst_strobes", {28'd0, bus.flush, bus.redirect, bus.epc_we_h, bus.epc_r_h}, 32'd0);
        rst = 1'b1;

        // Table-driven IDLE decisions
        for (int i = 0; i < 16; i++) begin
            do_reset();
            if (vecs[i].clr_exl) do_eret(32'h0040_0000);
            bus.epc_rd    = 32'h0040_0100;
            bus.m_valid   = vecs[i].valid;
            bus.m_pc      = vecs[i].pc;
            bus.m_bd      = vecs[i].bd;
            bus.m_eret    = vecs[i].eret;
            set_exc(vecs[i].exc);
            bus.sw_ip     = vecs[i].sw;
            bus.status_ie = vecs[i].ie;
            bus.status_im = vecs[i].im;
            step();
            chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].take | vecs[i].is_eret));
            chk($sformatf("v%0d_epc_we_h", i), 32'(bus.epc_we_h), 32'(vecs[i].we));
            chk($sformatf("v%0d_epc_r_h", i), 32'(bus.epc_r_h), 32'(vecs[i].is_eret));
            chk($sformatf("v%0d_redirect", i), 32'(bus.redirect), 32'(vecs[i].is_eret));
            chk($sformatf("v%0d_exc_code", i), 32'(bus.exc_code), 32'(vecs[i].code));
            if (vecs[i].take) begin
                chk($sformatf("v%0d_epc_pc", i), bus.epc_pc, vecs[i].pc);
                chk($sformatf("v%0d_epc_bd", i), 32'(bus.epc_bd), 32'(vecs[i].bd));
                chk($sformatf("v%0d_cause_bd", i), 32'(bus.cause_bd), 32'(vecs[i].bd));
            end
            if (vecs[i].is_eret)
                chk($sformatf("v%0d_eret_pc", i), bus.redirect_pc, 32'h0040_0100);
            clear_inputs();
            step();
            if (vecs[i].take) begin
                chk($sformatf("v%0d_vec_redirect", i), 32'(bus.redirect), 32'd1);
                chk($sformatf("v%0d_vec_pc", i), bus.redirect_pc, VEC);
                chk($sformatf("v%0d_vec_flush", i), 32'(bus.flush), 32'd1);
                chk($sformatf("v%0d_vec_exl", i), 32'(bus.exl), 32'd1);
            end else if (vecs[i].is_eret) begin
                chk($sformatf("v%0d_eret_exl", i), 32'(bus.exl), 32'd0);
                chk($sformatf("v%0d_eret_done", i), 32'(bus.redirect), 32'd0);
            end else begin
                chk($sformatf("v%0d_idle_flush", i), 32'(bus.flush), 32'd0);
            end
            step();
            chk($sformatf("v%0d_end_redirect", i), 32'(bus.redirect), 32'd0);
            chk($sformatf("v%0d_end_flush", i), 32'(bus.flush), 32'd0);
        end

        // Interrupt synchroniser latency and delivery
        do_reset();
        do_eret(32'h0040_0000);
        bus.status_ie = 1'b1;
        bus.status_im = 8'h04;
        bus.hw_int    = 6'b000001;
        step();
        chk("int_sync_1cyc", 32'(bus.ip_hw[0]), 32'd0);
        step();
        chk("int_sync_2cyc", 32'(bus.ip_hw[0]), 32'd1);
        chk("int_no_valid", 32'(bus.flush), 32'd0);
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h0040_0200;
        step();
        chk("int_taken", 32'(bus.flush), 32'd1);
        chk("int_code", 32'(bus.exc_code), 32'd0);
        chk("int_epc_pc", bus.epc_pc, 32'h0040_0200);
        clear_inputs();
        step();
        step();

        do_reset();
        do_eret(32'h0040_0000);
        bus.status_ie = 1'b1;
        bus.status_im = 8'h00;
        bus.hw_int    = 6'b000001;
        step();
        step();
        step();
        bus.m_valid = 1'b1;
        step();
        chk("int_masked_im", 32'(bus.flush), 32'd0);
        clear_inputs();

        // Nested exception keeps EPC; inputs ignored outside IDLE
        do_reset();
        do_eret(32'h0040_0000);
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h0040_0300;
        bus.exc_ov  = 1'b1;
        step();
        bus.exc_ov  = 1'b0;
        bus.exc_sys = 1'b1;
        bus.m_eret  = 1'b1;
        bus.m_pc    = 32'h0040_0304;
        step();
        chk("busy_code_hold", 32'(bus.exc_code), 32'd12);
        chk("busy_no_eret", 32'(bus.epc_r_h), 32'd0);
        chk("busy_redirect_pc", bus.redirect_pc, VEC);
        clear_inputs();
        step();
        chk("busy_back_idle", 32'(bus.flush), 32'd0);
        chk("busy_epc_model", epc_model, 32'h0040_0300);
        chk("nest_exl_set", 32'(bus.exl), 32'd1);
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h0040_0400;
        bus.exc_ri  = 1'b1;
        step();
        chk("nest_flush", 32'(bus.flush), 32'd1);
        chk("nest_we_h", 32'(bus.epc_we_h), 32'd0);
        chk("nest_code", 32'(bus.exc_code), 32'd10);
        clear_inputs();
        step();
        chk("nest_redirect", 32'(bus.redirect), 32'd1);
        chk("nest_redirect_pc", bus.redirect_pc, VEC);
        step();
        chk("nest_epc_kept", epc_model, 32'h0040_0300);

        // Reset asserted during FLUSH
        do_reset();
        do_eret(32'h0040_0000);
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h0040_0500;
        bus.exc_ov  = 1'b1;
        step();
        chk("rf_in_flush", 32'(bus.flush), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rf_flush", 32'(bus.flush), 32'd0);
        chk("rf_we_h", 32'(bus.epc_we_h), 32'd0);
        chk("rf_exl", 32'(bus.exl), 32'd1);
        chk("rf_epc_pc", bus.epc_pc, 32'd0);
        chk("rf_code", 32'(bus.exc_code), 32'd0);
        clear_inputs();
        step();
        chk("rf_no_redirect", 32'(bus.redirect), 32'd0);
        rst = 1'b1;
        step();
        chk("rf_after_redirect", 32'(bus.redirect), 32'd0);
        chk("rf_after_flush", 32'(bus.flush), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- CP0 exception/interrupt controller sitting directly upstream of the EPC unit.
- Samples exception flags and interrupt lines for the instruction in the memory stage, prioritises them, and runs a short entry sequence.
- The entry sequence flushes the pipeline, drives the EPC hardware-write strobe with the faulting PC and branch-delay flag, and redirects fetch to the handler vector.
- Also handles ERET: reads EPC back, clears EXL and redirects fetch.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, handler entry address.
- NUM_HW_INT, 6, number of external interrupt lines.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- m_valid  in  1  memory-stage instruction valid (not a bubble)
- m_pc  in  32  memory-stage instruction PC
- m_bd  in  1  memory-stage instruction is in a branch-delay slot
- m_eret  in  1  memory-stage instruction is ERET
- exc_adel_if  in  1  fetch address error
- exc_ri  in  1  reserved instruction
- exc_ov  in  1  arithmetic overflow
- exc_sys  in  1  SYSCALL
- exc_bp  in  1  BREAK
- exc_adel_d  in  1  data load address error
- exc_ades_d  in  1  data store address error
- hw_int  in  NUM_HW_INT  asynchronous external interrupt lines
- sw_ip  in  2  software interrupt pending bits (Cause.IP[1:0])
- status_ie  in  1  Status.IE
- status_im  in  8  Status.IM
- epc_rd  in  32  EPC read data
- epc_we_h  out  1  EPC hardware write strobe
- epc_bd  out  1  branch-delay flag to EPC
- epc_pc  out  32  faulting PC to EPC
- epc_r_h  out  1  EPC hardware read request
- exl  out  1  Status.EXL
- exc_code  out  5  Cause.ExcCode
- cause_bd  out  1  Cause.BD
- ip_hw  out  NUM_HW_INT  synchronised Cause.IP[7:2]
- flush  out  1  kill all pipeline stages up to and including M
- redirect  out  1  fetch redirect valid
- redirect_pc  out  32  fetch redirect target

Behaviour:
- Reset (rst low, async) values: state=IDLE, exl=1, exc_code=0, cause_bd=0, epc_pc=0, epc_bd=0, ip_hw=0, all strobes 0.
- hw_int passes through a two-flop synchroniser into ip_hw, so there are 2 cycles of latency before it is visible.
- pend = {ip_hw, sw_ip} & status_im; int_req = status_ie & ~exl & |pend.
- Priority, highest first; exc_code in brackets:
  - int_req (0)
  - adel_if (4)
  - ri (10)
  - ov (12)
  - sys (8)
  - bp (9)
  - adel_d (4)
  - ades_d (5)
- All exceptions and ERET require m_valid=1.
- IDLE state:
  - If any exception is taken: latch exc_code, cause_bd=m_bd, epc_pc=m_pc, epc_bd=m_bd, and a flag upd_epc=~exl. Go to FLUSH.
  - Otherwise, if m_eret: go to ERET.
  - An exception beats ERET in the same cycle.
- FLUSH (1 cycle):
  - flush=1, epc_we_h=upd_epc, exl set to 1 at the end of the cycle.
  - Go to VECTOR.
- VECTOR (1 cycle):
  - redirect=1, redirect_pc=EXC_VECTOR, flush=1.
  - Go to IDLE.
- ERET (1 cycle):
  - epc_r_h=1, flush=1, redirect=1, redirect_pc=epc_rd, exl cleared at the end of the cycle.
  - Go to IDLE.
- Exception-to-redirect latency is fixed at 2 cycles after detection.
- All exception inputs and m_eret are ignored outside IDLE.
- Exception while exl=1:
  - Still vectors and updates exc_code.
  - epc_we_h stays 0 and EPC is preserved.
  - Interrupts are masked.
- epc_pc/epc_bd are held stable from the FLUSH cycle until the next exception is taken.
- The PC adjustment for branch-delay slots is done by the EPC unit; this block passes m_pc unmodified.
- Reset asserted mid-sequence: return immediately to IDLE with reset values; no partial redirect.

Decomposition:
- Shared CP0 package holds:
  - ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12)
  - state encoding (IDLE, FLUSH, VECTOR, ERET)
  - EXC_VECTOR default
- One sub-module: int_sync, a parameterised two-flop synchroniser with async active-low reset.

Test Plan:
- Overflow case:
  - Stimulus: after reset, drop exl by ERET with epc_rd=32'h0040_0000; then m_valid=1, exc_ov=1, m_pc=32'h0040_0010, m_bd=0.
  - Required: next cycle flush=1, epc_we_h=1, epc_pc=32'h0040_0010, exc_code=12; following cycle redirect=1, redirect_pc=32'hBFC0_0380; exl=1.
- Branch-delay syscall:
  - Stimulus: exl=0, exc_sys=1, m_bd=1, m_pc=32'h0040_0024.
  - Required: epc_bd=1, cause_bd=1, exc_code=8.
- Interrupt:
  - Stimulus: exl=0, ie=1, im=8'h04, hw_int[0] rises.
  - Required: ip_hw[0]=1 exactly 2 cycles later; exception taken with exc_code=0 on the next valid instruction; with im=0 there is no exception.
- Priority:
  - Stimulus: exc_ri, exc_ov and exc_bp asserted together.
  - Required: exc_code=10; with ERET also asserted, ERET is ignored.
- Nested exception:
  - Stimulus: exception with exl=1.
  - Required: epc_we_h stays 0, redirect to the vector still occurs, EPC value unchanged.
- ERET and reset:
  - Stimulus: ERET with epc_rd=32'h0040_0100.
  - Required: epc_r_h=1, redirect_pc=32'h0040_0100, exl=0 next cycle.
  - Stimulus: rst low during FLUSH.
  - Required: no redirect; all outputs return to reset values asynchronously.
